// File: rtl/ptp_bridge_tx_igr_arb_sched.sv
// Packet-level scheduler for the shared TX ingress stream: picks one requester per
// packet (round-robin or strict priority), holds it to EOP and drives the mux select.
module ptp_bridge_tx_igr_arb_sched #(
  parameter int unsigned NUM_PORTS     = 9,
  parameter int unsigned PORTS_WIDTH   = 4,
  parameter int unsigned STALL_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_PORTS-1:0]   cfg_port_en,
  input  logic                   cfg_strict_prio,
  input  logic [NUM_PORTS-1:0]   in_tvalid,
  input  logic [NUM_PORTS-1:0]   in_tlast,
  output logic [NUM_PORTS-1:0]   in_tready,
  input  logic                   out_tready,
  output logic                   out_sel_vld,
  output logic [PORTS_WIDTH-1:0] out_sel,
  output logic                   out_sop,
  output logic                   stall_err,
  output logic [31:0]            pkt_cnt
);

  localparam int unsigned STALL_W = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;
  localparam int unsigned CNT_W   = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [PORTS_WIDTH-1:0] grant_q, grant_d;
  logic [PORTS_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic                   first_beat_q, first_beat_d;
  logic [STALL_W-1:0]     stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]       pkt_cnt_q, pkt_cnt_d;

  logic [NUM_PORTS-1:0]   elig;
  logic [NUM_PORTS-1:0]   gnt_oh;
  logic                   g_valid;
  logic                   g_last;
  logic                   win_vld;
  logic [PORTS_WIDTH-1:0] win_idx;
  logic [PORTS_WIDTH-1:0] rr_next;

  assign elig    = in_tvalid & cfg_port_en;
  assign g_valid = |(in_tvalid & gnt_oh);
  assign g_last  = |(in_tlast & gnt_oh);
  assign rr_next = (32'(grant_q) == NUM_PORTS - 1) ? '0 : grant_q + PORTS_WIDTH'(1);
  assign pkt_cnt = pkt_cnt_q;

  // One-hot decode of the held grant
  always_comb begin
    gnt_oh = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      gnt_oh[i] = (32'(grant_q) == i);
    end
  end

  // Winner select; loops run high-to-low so the nearest candidate is written last
  always_comb begin
    int unsigned idx;
    idx     = 0;
    win_vld = 1'b0;
    win_idx = '0;
    if (cfg_strict_prio) begin
      for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
        if (elig[i]) begin
          win_vld = 1'b1;
          win_idx = PORTS_WIDTH'(i);
        end
      end
    end else begin
      for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
        idx = 32'(rr_ptr_q) + 32'(i);
        if (idx >= NUM_PORTS) begin
          idx = idx - NUM_PORTS;
        end
        if (elig[idx]) begin
          win_vld = 1'b1;
          win_idx = PORTS_WIDTH'(idx);
        end
      end
    end
  end

  // Next-state, watchdog and stream outputs
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    first_beat_d = first_beat_q;
    stall_cnt_d  = stall_cnt_q;
    pkt_cnt_d    = pkt_cnt_q;
    in_tready    = '0;
    out_sel_vld  = 1'b0;
    out_sel      = '0;
    out_sop      = 1'b0;
    stall_err    = 1'b0;

    case (state_q)
      IDLE: begin
        stall_cnt_d = '0;
        if (win_vld) begin
          grant_d      = win_idx;
          first_beat_d = 1'b1;
          state_d      = XFER;
        end
      end

      XFER: begin
        out_sel_vld = 1'b1;
        out_sel     = grant_q;
        out_sop     = first_beat_q;
        in_tready   = gnt_oh & {NUM_PORTS{out_tready}};

        if (g_valid && out_tready) begin
          first_beat_d = 1'b0;
          if (g_last) begin
            pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
            rr_ptr_d  = rr_next;
            state_d   = IDLE;
          end
        end

        // Only source starvation counts; downstream backpressure keeps tvalid high
        if (g_valid) begin
          stall_cnt_d = '0;
        end else if (stall_cnt_q == STALL_W'(STALL_TIMEOUT - 1)) begin
          stall_err   = 1'b1;
          stall_cnt_d = '0;
        end else begin
          stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      first_beat_q <= 1'b0;
      stall_cnt_q  <= '0;
      pkt_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      first_beat_q <= first_beat_d;
      stall_cnt_q  <= stall_cnt_d;
      pkt_cnt_q    <= pkt_cnt_d;
    end
  end

endmodule
